// File: rtl/ariane_pkg.sv
// ariane_pkg: shared types for the commit queue.
//   exception_t        - cause/tval plus valid flag from a functional unit
//   scoreboard_entry_t - one in-flight instruction as held by the queue
//   TRANS_ID_BITS      - slot index width for the default queue depth
//   NR_SB_ENTRIES      - default queue depth
package ariane_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned NR_SB_ENTRIES = 8;
  localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [XLEN-1:0]          pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [4:0]               rd;
    logic [XLEN-1:0]          result;
    logic                     valid;
    exception_t               ex;
  } scoreboard_entry_t;

endpackage

// File: rtl/commit_queue_wb_match.sv
// commit_queue_wb_match: decodes the writeback ports into a per-slot hit
// vector and, for each hit slot, the index of the winning port.
//   wb_valid_i    - per-port writeback valid
//   wb_trans_id_i - per-port target slot
//   occupied_i    - per-slot occupied flag; writebacks to free slots are dropped
//   hit_o         - per-slot: some valid port targets this occupied slot
//   sel_o         - per-slot: lowest-index port that targets it
module commit_queue_wb_match #(
  parameter int unsigned NR_ENTRIES  = 8,
  parameter int unsigned NR_WB_PORTS = 4,
  parameter int unsigned IdW         = 3,
  parameter int unsigned PortW       = 2
) (
  input  logic [NR_WB_PORTS-1:0]           wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][IdW-1:0]  wb_trans_id_i,
  input  logic [NR_ENTRIES-1:0]            occupied_i,
  output logic [NR_ENTRIES-1:0]            hit_o,
  output logic [NR_ENTRIES-1:0][PortW-1:0] sel_o
);

  always_comb begin
    hit_o = '0;
    sel_o = '0;
    for (int unsigned s = 0; s < NR_ENTRIES; s++) begin
      // ascending scan, first match latched: lowest port index wins
      for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
        if (!hit_o[s] && occupied_i[s] && wb_valid_i[p] &&
            (wb_trans_id_i[p] == IdW'(s))) begin
          hit_o[s] = 1'b1;
          sel_o[s] = PortW'(p);
        end
      end
    end
  end

endmodule

// File: rtl/commit_queue.sv
// commit_queue: circular in-order commit buffer with per-slot occupied/done
// tracking, out-of-order writeback and up to NR_COMMIT_PORTS in-order retires.
//   clk_i, rst_ni          - clock, synchronous active-low reset
//   flush_i                - discard every entry
//   issue_valid_i/_instr_i - new entry offered
//   issue_ready_o          - room for one more entry (registered count only)
//   issue_trans_id_o       - slot the offered entry will occupy
//   wb_valid_i/_trans_id_i/_result_i/_ex_i - writeback ports
//   commit_instr_o         - oldest entries, port 0 oldest
//   commit_ack_i           - contiguous retire acks from port 0
//   empty_o, count_o       - occupancy
// Optional: define COMMIT_QUEUE_WB_BYPASS_EN to forward same-cycle writebacks
// onto commit_instr_o; otherwise writebacks appear one cycle later.
module commit_queue
  import ariane_pkg::*;
#(
  parameter  int unsigned NR_ENTRIES      = NR_SB_ENTRIES,
  parameter  int unsigned NR_COMMIT_PORTS = 2,
  parameter  int unsigned NR_WB_PORTS     = 4,
  localparam int unsigned IdW             = $clog2(NR_ENTRIES)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  flush_i,
  input  logic                                  issue_valid_i,
  input  scoreboard_entry_t                     issue_instr_i,
  output logic                                  issue_ready_o,
  output logic [IdW-1:0]                        issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]                wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][IdW-1:0]       wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0][XLEN-1:0]      wb_result_i,
  input  exception_t [NR_WB_PORTS-1:0]          wb_ex_i,
  output scoreboard_entry_t [NR_COMMIT_PORTS-1:0] commit_instr_o,
  input  logic [NR_COMMIT_PORTS-1:0]            commit_ack_i,
  output logic                                  empty_o,
  output logic [IdW:0]                          count_o
);

  localparam int unsigned PortW = (NR_WB_PORTS > 1) ? $clog2(NR_WB_PORTS) : 1;

  logic [NR_ENTRIES-1:0] occ_q, occ_d;
  logic [NR_ENTRIES-1:0] done_q, done_d;
  logic [IdW-1:0]        issue_ptr_q, issue_ptr_d;
  logic [IdW-1:0]        commit_ptr_q, commit_ptr_d;
  logic [IdW:0]          count_q, count_d;

  scoreboard_entry_t mem_q [NR_ENTRIES];

  logic [NR_ENTRIES-1:0]            wb_hit;
  logic [NR_ENTRIES-1:0][PortW-1:0] wb_sel;

  logic              issue_fire;
  scoreboard_entry_t issue_entry;
  logic [IdW:0]      pop_cnt;
  logic [NR_COMMIT_PORTS-1:0][IdW-1:0] commit_idx;

  commit_queue_wb_match #(
    .NR_ENTRIES (NR_ENTRIES),
    .NR_WB_PORTS(NR_WB_PORTS),
    .IdW        (IdW),
    .PortW      (PortW)
  ) u_wb_match (
    .wb_valid_i   (wb_valid_i),
    .wb_trans_id_i(wb_trans_id_i),
    .occupied_i   (occ_q),
    .hit_o        (wb_hit),
    .sel_o        (wb_sel)
  );

  assign issue_ready_o    = (count_q < (IdW+1)'(NR_ENTRIES));
  assign issue_fire       = issue_valid_i & issue_ready_o;
  assign issue_trans_id_o = issue_ptr_q;
  assign empty_o          = (count_q == '0);
  assign count_o          = count_q;

  always_comb begin
    issue_entry          = issue_instr_i;
    issue_entry.ex.valid = 1'b0;
  end

  always_comb begin
    pop_cnt = '0;
    for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
      commit_idx[i] = commit_ptr_q + IdW'(i);
      pop_cnt       = pop_cnt + (IdW+1)'(commit_ack_i[i]);
    end
  end

  always_comb begin
    occ_d        = occ_q;
    done_d       = done_q;
    issue_ptr_d  = issue_ptr_q;
    commit_ptr_d = commit_ptr_q;
    count_d      = count_q;
    if (flush_i) begin
      occ_d        = '0;
      done_d       = '0;
      issue_ptr_d  = '0;
      commit_ptr_d = '0;
      count_d      = '0;
    end else begin
      done_d = done_q | wb_hit;
      for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
        if (commit_ack_i[i]) begin
          occ_d[commit_idx[i]]  = 1'b0;
          done_d[commit_idx[i]] = 1'b0;
        end
      end
      // issue slot is free (count < depth), so it never collides with a pop
      if (issue_fire) begin
        occ_d[issue_ptr_q]  = 1'b1;
        done_d[issue_ptr_q] = 1'b0;
        issue_ptr_d         = issue_ptr_q + 1'b1;
      end
      commit_ptr_d = commit_ptr_q + IdW'(pop_cnt);
      count_d      = count_q + (IdW+1)'(issue_fire) - pop_cnt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      occ_q        <= '0;
      done_q       <= '0;
      issue_ptr_q  <= '0;
      commit_ptr_q <= '0;
      count_q      <= '0;
    end else begin
      occ_q        <= occ_d;
      done_q       <= done_d;
      issue_ptr_q  <= issue_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      count_q      <= count_d;
    end
  end

  // Payload storage carries no reset; validity lives in occ_q/done_q.
  always_ff @(posedge clk_i) begin
    for (int unsigned s = 0; s < NR_ENTRIES; s++) begin
      if (issue_fire && (issue_ptr_q == IdW'(s))) begin
        mem_q[s] <= issue_entry;
      end else if (wb_hit[s]) begin
        mem_q[s].result <= wb_result_i[wb_sel[s]];
        if (wb_ex_i[wb_sel[s]].valid) begin
          mem_q[s].ex <= wb_ex_i[wb_sel[s]];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
      commit_instr_o[i]       = mem_q[commit_idx[i]];
      commit_instr_o[i].valid = occ_q[commit_idx[i]] & done_q[commit_idx[i]];
`ifdef COMMIT_QUEUE_WB_BYPASS_EN
      if (wb_hit[commit_idx[i]]) begin
        commit_instr_o[i].valid  = 1'b1;
        commit_instr_o[i].result = wb_result_i[wb_sel[commit_idx[i]]];
        if (wb_ex_i[wb_sel[commit_idx[i]]].valid) begin
          commit_instr_o[i].ex = wb_ex_i[wb_sel[commit_idx[i]]];
        end
      end
`endif
    end
  end

  for (genvar i = 0; i < NR_COMMIT_PORTS; i++) begin : g_ack_chk
    a_ack_valid : assert property (@(posedge clk_i) disable iff (!rst_ni)
      commit_ack_i[i] |-> commit_instr_o[i].valid);
    if (i > 0) begin : g_contig
      a_ack_contig : assert property (@(posedge clk_i) disable iff (!rst_ni)
        commit_ack_i[i] |-> commit_ack_i[i-1]);
    end
  end

endmodule

// File: tb/tb_commit_queue.sv
module tb_commit_queue;
  import ariane_pkg::*;

  localparam int N  = 8;
  localparam int NC = 2;
  localparam int NW = 4;

  logic clk = 1'b0;
  logic rst_ni;
  logic flush_i;
  logic issue_valid_i;
  scoreboard_entry_t issue_instr_i;
  logic issue_ready_o;
  logic [2:0] issue_trans_id_o;
  logic [NW-1:0] wb_valid_i;
  logic [NW-1:0][2:0] wb_trans_id_i;
  logic [NW-1:0][31:0] wb_result_i;
  exception_t [NW-1:0] wb_ex_i;
  scoreboard_entry_t [NC-1:0] commit_instr_o;
  logic [NC-1:0] commit_ack_i;
  logic empty_o;
  logic [3:0] count_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  commit_queue #(
    .NR_ENTRIES     (N),
    .NR_COMMIT_PORTS(NC),
    .NR_WB_PORTS    (NW)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .issue_valid_i   (issue_valid_i),
    .issue_instr_i   (issue_instr_i),
    .issue_ready_o   (issue_ready_o),
    .issue_trans_id_o(issue_trans_id_o),
    .wb_valid_i      (wb_valid_i),
    .wb_trans_id_i   (wb_trans_id_i),
    .wb_result_i     (wb_result_i),
    .wb_ex_i         (wb_ex_i),
    .commit_instr_o  (commit_instr_o),
    .commit_ack_i    (commit_ack_i),
    .empty_o         (empty_o),
    .count_o         (count_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: an ordered list of in-flight instructions, oldest first.
  typedef struct {
    int                id;
    scoreboard_entry_t e;
    bit                done;
  } m_t;
  m_t mq[$];
  int nid = 0;
  bit minit = 0;

  always @(posedge clk) begin
    bit rdy;
    int pops;
    bit [N-1:0] taken;
    m_t n;
    if (!rst_ni || flush_i) begin
      mq.delete();
      nid = 0;
      if (!rst_ni) minit = 1;
    end else begin
      rdy = (mq.size() < N);
      taken = '0;
      for (int p = 0; p < NW; p++) begin
        if (wb_valid_i[p] && !taken[wb_trans_id_i[p]]) begin
          for (int k = 0; k < mq.size(); k++) begin
            if (mq[k].id == int'(wb_trans_id_i[p])) begin
              taken[wb_trans_id_i[p]] = 1'b1;
              mq[k].done = 1'b1;
              mq[k].e.result = wb_result_i[p];
              if (wb_ex_i[p].valid) mq[k].e.ex = wb_ex_i[p];
            end
          end
        end
      end
      pops = int'(commit_ack_i[0]) + int'(commit_ack_i[1]);
      for (int j = 0; j < pops; j++) if (mq.size() > 0) void'(mq.pop_front());
      if (issue_valid_i && rdy) begin
        n.id = nid;
        n.e = issue_instr_i;
        n.e.ex.valid = 1'b0;
        n.done = 1'b0;
        mq.push_back(n);
        nid = (nid + 1) % N;
      end
    end
  end

  always @(negedge clk) begin
    bit ev;
    scoreboard_entry_t ee;
    bit fwd;
    #2;
    if (minit) begin
      chk("issue_ready", issue_ready_o, mq.size() < N);
      chk("issue_trans_id", issue_trans_id_o, nid);
      chk("count", count_o, mq.size());
      chk("empty", empty_o, mq.size() == 0);
      for (int i = 0; i < NC; i++) begin
        ev = 1'b0;
        ee = '0;
        if (i < mq.size()) begin
          ev = mq[i].done;
          ee = mq[i].e;
`ifdef COMMIT_QUEUE_WB_BYPASS_EN
          fwd = 1'b0;
          for (int p = 0; p < NW; p++) begin
            if (!fwd && wb_valid_i[p] && int'(wb_trans_id_i[p]) == mq[i].id) begin
              fwd = 1'b1;
              ev = 1'b1;
              ee.result = wb_result_i[p];
              if (wb_ex_i[p].valid) ee.ex = wb_ex_i[p];
            end
          end
`else
          fwd = 1'b0;
`endif
        end
        chk($sformatf("commit%0d_valid", i), commit_instr_o[i].valid, ev);
        if (ev) begin
          chk($sformatf("commit%0d_result", i), commit_instr_o[i].result, ee.result);
          chk($sformatf("commit%0d_pc", i), commit_instr_o[i].pc, ee.pc);
          chk($sformatf("commit%0d_exv", i), commit_instr_o[i].ex.valid, ee.ex.valid);
          if (ee.ex.valid)
            chk($sformatf("commit%0d_cause", i), commit_instr_o[i].ex.cause, ee.ex.cause);
        end
      end
    end
  end

  task automatic idle();
    flush_i = 1'b0;
    issue_valid_i = 1'b0;
    issue_instr_i = '0;
    wb_valid_i = '0;
    wb_trans_id_i = '0;
    wb_result_i = '0;
    wb_ex_i = '0;
    commit_ack_i = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #3;
  endtask

  // ex.valid is offered set so that the queue must clear it on issue
  task automatic set_issue(input logic [31:0] pc);
    issue_valid_i = 1'b1;
    issue_instr_i = '0;
    issue_instr_i.pc = pc;
    issue_instr_i.rd = pc[4:0];
    issue_instr_i.ex.valid = 1'b1;
    issue_instr_i.ex.cause = 32'hdead;
  endtask

  task automatic set_wb(input int p, input int id, input logic [31:0] res,
                        input bit exv, input logic [31:0] cause);
    wb_valid_i[p] = 1'b1;
    wb_trans_id_i[p] = 3'(id);
    wb_result_i[p] = res;
    wb_ex_i[p] = '0;
    wb_ex_i[p].valid = exv;
    wb_ex_i[p].cause = cause;
  endtask

  initial begin
    idle();
    rst_ni = 1'b0;
    cyc();
    cyc();
    chk("rst_ready", issue_ready_o, 1);
    chk("rst_empty", empty_o, 1);
    chk("rst_count", count_o, 0);
    chk("rst_c0_valid", commit_instr_o[0].valid, 0);
    chk("rst_c1_valid", commit_instr_o[1].valid, 0);
    rst_ni = 1'b1;

    // three issues, out-of-order writeback
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("iss_tid", issue_trans_id_o, k);
      set_issue(32'h100 + 32'(4 * k));
      cyc();
    end
    chk("cnt3", count_o, 3);
    idle(); set_wb(0, 1, 32'h11, 0, 0); cyc();
    chk("wb1_c0_valid", commit_instr_o[0].valid, 0);
    chk("wb1_c1_valid", commit_instr_o[1].valid, 1);
    chk("wb1_c1_result", commit_instr_o[1].result, 32'h11);
    idle(); set_wb(0, 0, 32'h10, 0, 0); cyc();
    chk("wb0_c0_valid", commit_instr_o[0].valid, 1);
    chk("wb0_c0_result", commit_instr_o[0].result, 32'h10);
    chk("wb0_c0_exv", commit_instr_o[0].ex.valid, 0);
    idle(); commit_ack_i = 2'b11; cyc();
    chk("ack2_count", count_o, 1);

    // writeback to a free slot (id4) must be dropped
    idle(); set_wb(1, 4, 32'h44, 0, 0); set_issue(32'h10c); cyc();
    idle(); set_issue(32'h110); cyc();
    idle(); set_wb(0, 2, 32'h22, 0, 0); cyc();
    idle(); commit_ack_i = 2'b01; cyc();
    chk("free_wb_c1_valid", commit_instr_o[1].valid, 0);
    idle(); flush_i = 1'b1; cyc();
    chk("flush_count", count_o, 0);
    chk("flush_tid", issue_trans_id_o, 0);

    // fill to full
    for (int k = 0; k < N; k++) begin
      idle(); set_issue(32'h200 + 32'(4 * k)); cyc();
    end
    chk("full_ready", issue_ready_o, 0);
    chk("full_count", count_o, 8);
    idle(); set_wb(1, 3, 32'h0, 1, 32'd2); cyc();
    idle(); set_wb(0, 3, 32'h33, 0, 0); cyc();
    idle();
    set_wb(0, 5, 32'hA, 0, 0); set_wb(2, 5, 32'hB, 0, 0);
    set_wb(1, 0, 32'h100, 0, 0); set_wb(3, 1, 32'h101, 0, 0);
    cyc();
    chk("full2_ready", issue_ready_o, 0);
    chk("full2_count", count_o, 8);
    idle(); set_issue(32'h300); commit_ack_i = 2'b11; cyc();
    chk("refused_count", count_o, 6);
    chk("refused_ready", issue_ready_o, 1);
    chk("wrap_tid", issue_trans_id_o, 0);
    idle(); set_issue(32'h300); cyc();
    chk("accept_count", count_o, 7);
    chk("accept_tid", issue_trans_id_o, 1);
    chk("ex_c1_exv", commit_instr_o[1].ex.valid, 1);
    chk("ex_c1_cause", commit_instr_o[1].ex.cause, 2);
    chk("ex_c1_result", commit_instr_o[1].result, 32'h33);
    idle(); set_wb(0, 2, 32'h22, 0, 0); cyc();
    idle(); commit_ack_i = 2'b01; cyc();
    chk("ex_c0_valid", commit_instr_o[0].valid, 1);
    chk("ex_c0_exv", commit_instr_o[0].ex.valid, 1);
    chk("ex_c0_cause", commit_instr_o[0].ex.cause, 2);
    idle(); commit_ack_i = 2'b01; cyc();
    chk("prio_c1_valid", commit_instr_o[1].valid, 1);
    chk("prio_c1_result", commit_instr_o[1].result, 32'hA);

    // writeback latency on commit port 0
    idle(); set_wb(0, 4, 32'h44, 0, 0);
    #1;
`ifdef COMMIT_QUEUE_WB_BYPASS_EN
    chk("lat_N_valid", commit_instr_o[0].valid, 1);
`else
    chk("lat_N_valid", commit_instr_o[0].valid, 0);
`endif
    cyc();
    chk("lat_N1_valid", commit_instr_o[0].valid, 1);

    // flush overrides issue, writeback and ack
    idle(); flush_i = 1'b1; set_issue(32'h400); set_wb(1, 6, 32'h66, 0, 0);
    commit_ack_i = 2'b01; cyc();
    chk("fl_count", count_o, 0);
    chk("fl_empty", empty_o, 1);
    chk("fl_tid", issue_trans_id_o, 0);
    chk("fl_c0_valid", commit_instr_o[0].valid, 0);
    idle(); set_issue(32'h500); cyc();
    chk("post_fl_count", count_o, 1);

    // reset mid-operation
    idle(); set_wb(0, 0, 32'h55, 0, 0); cyc();
    chk("pre_rst_c0_valid", commit_instr_o[0].valid, 1);
    idle(); rst_ni = 1'b0; cyc();
    rst_ni = 1'b1;
    chk("mid_rst_count", count_o, 0);
    chk("mid_rst_empty", empty_o, 1);
    chk("mid_rst_c0_valid", commit_instr_o[0].valid, 0);
    idle(); cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/commit_queue.md
COMMIT_QUEUE -- requirements
Module: commit_queue

Interface
REQ-001 SHALL have parameter NR_ENTRIES, default 8, queue depth; power of two, 4..16; TRANS_ID_BITS = log2(NR_ENTRIES).
REQ-002 SHALL have parameter NR_COMMIT_PORTS, default 2, number of oldest entries presented for commit (1..2).
REQ-003 SHALL have parameter NR_WB_PORTS, default 4, number of writeback ports.
REQ-004 SHALL have one clock and a synchronous, active-low reset: clk_i input 1, the clock; rst_ni input 1, the reset.
REQ-005 flush_i  input  1  discard every entry.
REQ-006 issue_valid_i  input  1  new entry offered; issue_instr_i  input  scoreboard_entry_t  entry payload.
REQ-007 issue_ready_o  output  1  queue can accept an entry; issue_trans_id_o  output  TRANS_ID_BITS  slot given to the offered entry.
REQ-008 wb_valid_i  input  NR_WB_PORTS  result valid; wb_trans_id_i  input  NR_WB_PORTS x TRANS_ID_BITS  target slot.
REQ-009 wb_result_i  input  NR_WB_PORTS x XLEN  result data; wb_ex_i  input  NR_WB_PORTS x exception_t  exception from the functional unit.
REQ-010 commit_instr_o  output  NR_COMMIT_PORTS x scoreboard_entry_t  oldest entries, port 0 oldest.
REQ-011 commit_ack_i  input  NR_COMMIT_PORTS  entry retired this cycle.
REQ-012 empty_o  output  1  no occupied entries; count_o  output  TRANS_ID_BITS+1  occupied entries.

Function
REQ-013 Circular buffer with per-slot occupied and done bits, issue pointer, commit pointer and count; pointers wrap modulo NR_ENTRIES.
REQ-014 issue_ready_o = (count < NR_ENTRIES), from registered count only; a commit in the same cycle does not free a slot for issue.
REQ-015 On issue_valid_i && issue_ready_o: store payload at issue pointer, set occupied, clear done and stored ex.valid, then increment issue pointer; issue_trans_id_o always equals the issue pointer.
REQ-016 Writeback to an occupied slot: store result, set done; if wb_ex_i.valid, store the exception; a non-exception writeback leaves stored ex unchanged.
REQ-017 A writeback to an unoccupied slot is ignored; when several ports hit one slot in one cycle, the lowest port index wins.
REQ-018 commit_instr_o[i] = slot (commit pointer + i) with .valid = occupied && done; other fields are stored values.
REQ-019 commit_ack_i[i] pops slot (commit pointer + i); acks are contiguous from port 0; commit_ack_i[1] without [0], or an ack on an entry whose .valid is low, is illegal and checked by assertion.
REQ-020 Commit pointer advances by popcount(commit_ack_i); count next = count + push - popcount(ack).
REQ-021 Issue, writeback and commit in the same cycle to different slots all take effect; on a full queue, issue is refused even if ack frees a slot.
REQ-022 flush_i clears all occupied/done bits, both pointers and count in the next cycle and overrides same-cycle issue, writeback and ack.
REQ-023 empty_o = (count == 0).

Reset
REQ-024 On rst_ni low at a clock edge: pointers 0, count 0, all occupied/done 0; hence issue_ready_o=1, empty_o=1, count_o=0, all commit_instr_o[i].valid=0.
REQ-025 Reset asserted mid-operation discards every entry, as flush does; payload storage is not reset.

Configuration
REQ-026 Macro COMMIT_QUEUE_WB_BYPASS_EN defined: a writeback that targets a slot currently on commit_instr_o is forwarded combinationally (valid, result, ex) in the same cycle.
REQ-027 Macro undefined: writeback becomes visible on commit_instr_o one cycle after wb_valid_i; no combinational path from wb_*_i to commit_instr_o.

Structure
REQ-028 scoreboard_entry_t, exception_t, TRANS_ID_BITS and a NR_SB_ENTRIES default SHALL live in ariane_pkg; nothing new goes in the package beyond those.
REQ-029 One sub-module, commit_queue_wb_match, SHALL decode the writeback ports into a per-slot hit vector plus a selected port index.

Verification
REQ-030 After reset, issue 3 entries (ids 0,1,2), then writeback id1 then id0 -> commit_instr_o[0].valid rises only after id0 writeback; [1] shows id1 valid.
REQ-031 Fill 8 entries -> issue_ready_o=0 and count_o=8; ack 2 with issue_valid_i held -> issue refused that cycle, accepted next cycle with trans_id 0 (wrap).
REQ-032 Writeback wb_ex_i.valid=1, cause=2 to id3, then non-exception writeback to id3 -> committed entry shows ex.valid=1, cause=2.
REQ-033 Flush with issue_valid_i, wb_valid_i and commit_ack_i[0] all high -> next cycle count_o=0, empty_o=1, next issue gets trans_id 0.
REQ-034 Writeback to the commit-port-0 slot at cycle N -> .valid=1 at cycle N with COMMIT_QUEUE_WB_BYPASS_EN, at N+1 without.
REQ-035 Ports 0 and 2 writeback id5 with results 0xA and 0xB in one cycle -> stored result 0xA.
